alu_mdu_sequencer: RTL and testbench

- Multi-cycle multiply/divide sequencer that reuses the CPU's shared 32-bit ALU (ALUop 000 = add, 001 = sub); it adds no adder of its own.
- Takes a start request from the control unit and runs 32 iterations: shift-add for multiply, restoring division for divide.
- Drives the ALU operand and op lines on every RUN cycle, then returns a 32-bit result with a done pulse.
- Sits beside the ALU in the execute stage; the pipeline stalls on busy.

---
 rtl/alu_mdu_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_alu_mdu_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_sequencer.sv
// alu_mdu_sequencer
// Multi-cycle unsigned multiply/divide sequencer that borrows the shared
// execute-stage ALU. Multiply is shift-add, divide is restoring. Each
// operation takes 32 iterations. The module has no adder of its own.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             request, accepted in IDLE only
//   op[1:0]           00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   a, b              multiplicand/dividend, multiplier/divisor
//   alu_op/alu_a/alu_b  drive the shared ALU (add/sub) during RUN only
//   alu_result        combinational ALU output for the current cycle
//   busy              high while RUN or DONE (pipeline stall)
//   done              one-cycle pulse, result valid
//   result            final value, held until overwritten by the next op
//
// Build option
//   MDU_EARLY_OUT_EN  multiply ends as soon as the remaining multiplier
//                     bits are all zero; the partial product is re-aligned
//                     before the result is selected.
//
// State table
//   S_IDLE | waiting for start, ALU released to the pipeline
//   S_RUN  | one iteration per cycle using the shared ALU
//   S_DONE | done pulse, result valid, returns to IDLE
module alu_mdu_sequencer #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [2:0]      alu_op,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   input  logic [XLEN-1:0] alu_result,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   state_t            state;
   logic [1:0]        op_q;
   logic [XLEN-1:0]   a_q;
   logic [XLEN-1:0]   b_q;
   // hi/lo double as rem/quo for divide
   logic [XLEN-1:0]   hi;
   logic [XLEN-1:0]   lo;
   logic [CNT_W-1:0]  cnt;

   logic              is_div;
   logic [XLEN-1:0]   div_s;
   logic              div_q;
   logic              mul_carry;
   logic [XLEN-1:0]   hi_nxt;
   logic [XLEN-1:0]   lo_nxt;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   fin_result;
   logic              last_iter;

`ifdef MDU_EARLY_OUT_EN
   logic [XLEN-1:0]   mplr;
   logic [XLEN-1:0]   mplr_nxt;
   logic [CNT_W-1:0]  shamt;
`endif

   assign is_div = op_q[1];
   assign div_s  = {hi[XLEN-2:0], lo[XLEN-1]};

   always_comb begin
      alu_op = ALU_ADD;
      alu_a  = '0;
      alu_b  = '0;
      if (state == S_RUN) begin
         if (is_div) begin
            alu_op = ALU_SUB;
            alu_a  = div_s;
            alu_b  = b_q;
         end else begin
            alu_op = ALU_ADD;
            alu_a  = hi;
            alu_b  = lo[0] ? a_q : '0;
         end
      end
   end

   // Wrap-around of the 32-bit add is the carry out of the partial sum.
   assign mul_carry = (alu_result < hi);
   // When the shifted-out remainder MSB is set, s+2^32 always exceeds b;
   // the truncated ALU difference is still the correct remainder.
   assign div_q     = hi[XLEN-1] | (div_s >= b_q);

   always_comb begin
      if (is_div) begin
         hi_nxt = div_q ? alu_result : div_s;
         lo_nxt = {lo[XLEN-2:0], div_q};
      end else begin
         hi_nxt = {mul_carry, alu_result[XLEN-1:1]};
         lo_nxt = {alu_result[0], lo[XLEN-1:1]};
      end
   end

`ifdef MDU_EARLY_OUT_EN
   assign mplr_nxt  = mplr >> 1;
   assign shamt     = CNT_W'(XLEN - 1) - cnt;
   assign last_iter = (cnt == CNT_W'(XLEN - 1)) || (!is_div && (mplr_nxt == '0));
   // Undo the shifts that the skipped iterations would have performed.
   assign prod      = {hi_nxt, lo_nxt} >> shamt;
`else
   assign last_iter = (cnt == CNT_W'(XLEN - 1));
   assign prod      = {hi_nxt, lo_nxt};
`endif

   always_comb begin
      case (op_q)
         2'b00:   fin_result = prod[XLEN-1:0];
         2'b01:   fin_result = prod[2*XLEN-1:XLEN];
         2'b10:   fin_result = lo_nxt;
         default: fin_result = hi_nxt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         op_q   <= 2'b00;
         a_q    <= '0;
         b_q    <= '0;
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
`ifdef MDU_EARLY_OUT_EN
         mplr   <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q <= op;
                  a_q  <= a;
                  b_q  <= b;
                  cnt  <= '0;
                  hi   <= '0;
                  lo   <= op[1] ? a : b;
                  busy <= 1'b1;
`ifdef MDU_EARLY_OUT_EN
                  mplr <= b;
`endif
                  if (op[1] && (b == '0)) begin
                     state  <= S_DONE;
                     done   <= 1'b1;
                     result <= op[0] ? a : '1;
                  end else begin
                     state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               hi  <= hi_nxt;
               lo  <= lo_nxt;
               cnt <= cnt + CNT_W'(1);
`ifdef MDU_EARLY_OUT_EN
               mplr <= mplr_nxt;
`endif
               if (last_iter) begin
                  state  <= S_DONE;
                  done   <= 1'b1;
                  result <= fin_result;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mdu_sequencer.sv
module tb_alu_mdu_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] sb[$];

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[8];

   alu_mdu_sequencer #(.XLEN(32), .CNT_W(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .op         (op),
      .a          (a),
      .b          (b),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .busy       (busy),
      .done       (done),
      .result     (result)
   );

   always #5 clk = ~clk;

   // shared ALU stand-in
   always_comb begin
      alu_result = (alu_op == 3'b001) ? (alu_a - alu_b) : (alu_a + alu_b);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      p = {32'b0, x} * {32'b0, y};
      case (o)
         2'b00:   return p[31:0];
         2'b01:   return p[63:32];
         2'b10:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic int model_lat(input logic [1:0] o, input logic [31:0] y);
      int iters;
      if (o[1]) return (y == 0) ? 1 : 33;
`ifdef MDU_EARLY_OUT_EN
      iters = 1;
      for (int i = 0; i < 32; i++) if (y[i]) iters = i + 1;
      return iters + 1;
`else
      iters = 32;
      return iters + 1;
`endif
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int poke_at);
      int          lat;
      int          want;
      bit          seen;
      logic [31:0] exp;
      want = model_lat(o, y);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      sb.push_back(model(o, x, y));
      lat  = 0;
      seen = 0;
      while (!seen && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         start = 1'b0;
         if (lat == poke_at) begin
            start = 1'b1;
            op    = 2'b10;
            a     = 32'h0000_FFFF;
            b     = 32'd1;
         end
         if (lat == 1) begin
            check("busy_run", {31'b0, busy}, 32'd1);
            if (want > 1) begin
               if (o[1]) begin
                  check("alu_op_div", {29'b0, alu_op}, 32'd1);
                  check("alu_a_div", alu_a, {31'b0, x[31]});
                  check("alu_b_div", alu_b, y);
               end else begin
                  check("alu_op_mul", {29'b0, alu_op}, 32'd0);
                  check("alu_a_mul", alu_a, 32'd0);
                  check("alu_b_mul", alu_b, y[0] ? x : 32'd0);
               end
            end
         end
         if (done) seen = 1;
      end
      start = 1'b0;
      if (!seen) begin
         n_vec++;
         n_err++;
         $display("FAIL timeout op=%0d a=%h b=%h: no done in 100 cycles", o, x, y);
         sb.delete();
      end else begin
         exp = sb.pop_front();
         check("result", result, exp);
         check("latency", lat, want);
         @(posedge clk);
         #1;
         check("done_pulse", {31'b0, done}, 32'd0);
         check("busy_idle", {31'b0, busy}, 32'd0);
         check("alu_a_idle", alu_a, 32'd0);
         check("alu_b_idle", alu_b, 32'd0);
         check("alu_op_idle", {29'b0, alu_op}, 32'd0);
         check("result_hold", result, exp);
      end
   endtask

   initial begin
      int  poke;
      bit  saw_done;
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;

      vecs[0] = '{2'b00, 32'd7,          32'd6,          32'd42};
      vecs[1] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
      vecs[2] = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
      vecs[3] = '{2'b10, 32'd100,        32'd7,          32'd14};
      vecs[4] = '{2'b11, 32'd100,        32'd7,          32'd2};
      vecs[5] = '{2'b10, 32'h8000_0000,  32'd1,          32'h8000_0000};
      vecs[6] = '{2'b10, 32'd5,          32'd0,          32'hFFFF_FFFF};
      vecs[7] = '{2'b11, 32'd5,          32'd0,          32'd5};

      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",   {31'b0, busy}, 32'd0);
      check("rst_done",   {31'b0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_alu_a",  alu_a, 32'd0);
      check("rst_alu_b",  alu_b, 32'd0);
      check("rst_alu_op", {29'b0, alu_op}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // directed table; expected values are the hand-computed constants
      for (int i = 0; i < 8; i++) begin
         check("table_model", model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1);
      end

      // random operands, including small and zero divisors
      for (int i = 0; i < 10; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         case (i % 3)
            0:       rb = $urandom;
            1:       rb = 32'($urandom_range(0, 15));
            default: rb = $urandom >> $urandom_range(0, 31);
         endcase
         run_op(ro, ra, rb, -1);
      end

      // start while busy is ignored
`ifdef MDU_EARLY_OUT_EN
      poke = 2;
`else
      poke = 10;
`endif
      run_op(2'b00, 32'd3, 32'd3, poke);

      // reset in the middle of a divide
      op    = 2'b10;
      a     = 32'd1000;
      b     = 32'd3;
      start = 1'b1;
      sb.push_back(model(2'b10, 32'd1000, 32'd3));
      saw_done = 0;
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) saw_done = 1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      check("rst_mid_busy",   {31'b0, busy}, 32'd0);
      check("rst_mid_result", result, 32'd0);
      check("rst_mid_alu_op", {29'b0, alu_op}, 32'd0);
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (done || busy) saw_done = 1;
      end
      check("rst_no_done", {31'b0, saw_done}, 32'd0);
      run_op(2'b00, 32'd2, 32'd2, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
